ram_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM (DATA_WIDTH x 2**ADDR_WIDTH) among N_REQ requesters.

---
 rtl/ram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM among N_REQ requesters.
// One transaction in flight; read data is returned to the requester that won the grant.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        busy,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_data,
  output logic                        ram_we,
  input  logic [DATA_WIDTH-1:0]       ram_q
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                            state, state_nxt;
  logic [IW-1:0]                     last, last_nxt, win, win_nxt, pick;
  logic                              pick_ok, wr, wr_nxt;
  logic [N_REQ-1:0]                  gnt_nxt, rvalid_nxt;
  logic [DATA_WIDTH-1:0]             rdata_nxt, data_nxt;
  logic [ADDR_WIDTH-1:0]             addr_nxt;
  logic                              we_nxt, busy_nxt;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0]  addr_a;
  logic [N_REQ-1:0][DATA_WIDTH-1:0]  data_a;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign addr_a[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!pick_ok && req[idx]) begin
        pick_ok = 1'b1;
        pick    = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    win_nxt    = win;
    wr_nxt     = wr;
    gnt_nxt    = '0;
    rvalid_nxt = '0;
    rdata_nxt  = rdata;
    addr_nxt   = ram_addr;
    data_nxt   = ram_data;
    we_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt     = ACCESS;
          last_nxt      = pick;
          win_nxt       = pick;
          wr_nxt        = req_we[pick];
          addr_nxt      = addr_a[pick];
          data_nxt      = data_a[pick];
          we_nxt        = req_we[pick];
          gnt_nxt[pick] = 1'b1;
        end
      end
      // RAM samples addr/we/data on the edge leaving this state.
      ACCESS:  state_nxt = wr ? IDLE : RESP;
      RESP: begin
        rdata_nxt       = ram_q;
        rvalid_nxt[win] = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= IW'(N_REQ - 1);
      win      <= '0;
      wr       <= 1'b0;
      gnt      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      win      <= win_nxt;
      wr       <= wr_nxt;
      gnt      <= gnt_nxt;
      rvalid   <= rvalid_nxt;
      rdata    <= rdata_nxt;
      ram_addr <= addr_nxt;
      ram_data <= data_nxt;
      ram_we   <= we_nxt;
      busy     <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed + seeded-random bench for ram_port_arbiter with a behavioural sync RAM and shadow memory.
module tb_ram_port_arbiter;
  localparam int DW = 8, AW = 8, N = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  req = '0, req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;
  logic          busy, ram_we;

  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];
  int checks = 0, failures = 0;
  int multi_hot = 0, rv1_cnt = 0, pulse_cnt = 0;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if ((gnt & (gnt - 1'b1)) != 0 || (rvalid & (rvalid - 1'b1)) != 0) multi_hot++;
    if (rvalid[1]) rv1_cnt++;
    if (gnt != 0 || rvalid != 0) pulse_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_fields(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_data[p*DW +: DW] = d;
    req[p] = 1'b1;
  endtask

  task automatic reset_dut();
    req = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  // Issue one transaction; returns edges-to-grant and, for reads, edges from grant to rvalid.
  task automatic txn(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rd, output int ng, output int nv);
    set_fields(p, we, a, d);
    ng = 0; nv = 0; rd = '0;
    while (ng < 20) begin
      @(posedge clk); #1; ng++;
      if (gnt[p]) break;
    end
    req[p] = 1'b0;
    chk("gnt_seen", 32'(gnt[p]), 32'd1);
    if (we) shadow[a] = d;
    else begin
      while (nv < 10) begin
        @(posedge clk); #1; nv++;
        if (rvalid[p]) break;
      end
      chk("rvalid_seen", 32'(rvalid[p]), 32'd1);
      rd = rdata;
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [DW-1:0] t5_exp [3];
    int ng, nv, n0, n1, ntot, k, snap;
    int order [4];
    t5_exp[0] = 8'h11; t5_exp[1] = 8'h22; t5_exp[2] = 8'h33;

    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(1);

    // T1: write then read on port 0
    snap = rv1_cnt;
    txn(0, 1'b1, 8'h3C, 8'hA5, rd, ng, nv);
    chk("t1_wr_gnt_lat", 32'(ng), 32'd1);
    tick(2);
    txn(0, 1'b0, 8'h3C, 8'h00, rd, ng, nv);
    chk("t1_rd_gnt_lat", 32'(ng), 32'd1);
    chk("t1_rd_rvalid_lat", 32'(ng + nv), 32'd3);
    chk("t1_rdata", 32'(rd), 32'hA5);
    chk("t1_rvalid1_never", 32'(rv1_cnt - snap), 32'd0);

    // T2: both ports contend from reset
    reset_dut();
    set_fields(0, 1'b1, 8'h10, 8'h11);
    set_fields(1, 1'b1, 8'h11, 8'h22);
    n0 = 0; n1 = 0; ntot = 0;
    for (int c = 0; c < 16 && ntot < 4; c++) begin
      @(posedge clk); #1;
      if (gnt[0] && ntot < 4) begin
        order[ntot] = 0; ntot++;
        if (n0 == 0) begin shadow[8'h10] = 8'h11; set_fields(0, 1'b1, 8'h12, 8'h33); end
        else begin shadow[8'h12] = 8'h33; req[0] = 1'b0; end
        n0++;
      end
      if (gnt[1] && ntot < 4) begin
        order[ntot] = 1; ntot++;
        if (n1 == 0) begin shadow[8'h11] = 8'h22; set_fields(1, 1'b1, 8'h13, 8'h44); end
        else begin shadow[8'h13] = 8'h44; req[1] = 1'b0; end
        n1++;
      end
    end
    req = '0;
    chk("t2_grant_count", 32'(ntot), 32'd4);
    chk("t2_order0", 32'(order[0]), 32'd0);
    chk("t2_order1", 32'(order[1]), 32'd1);
    chk("t2_order2", 32'(order[2]), 32'd0);
    chk("t2_order3", 32'(order[3]), 32'd1);
    tick(2);
    txn(1, 1'b0, 8'h10, 8'h00, rd, ng, nv); chk("t2_rd10", 32'(rd), 32'h11);
    txn(0, 1'b0, 8'h11, 8'h00, rd, ng, nv); chk("t2_rd11", 32'(rd), 32'h22);
    txn(1, 1'b0, 8'h12, 8'h00, rd, ng, nv); chk("t2_rd12", 32'(rd), 32'h33);
    txn(0, 1'b0, 8'h13, 8'h00, rd, ng, nv); chk("t2_rd13", 32'(rd), 32'h44);

    // T3: address extremes
    txn(0, 1'b1, 8'hFF, 8'hFF, rd, ng, nv);
    txn(1, 1'b1, 8'h00, 8'h00, rd, ng, nv);
    txn(0, 1'b0, 8'hFF, 8'h00, rd, ng, nv); chk("t3_rdFF", 32'(rd), 32'hFF);
    txn(1, 1'b0, 8'h00, 8'h00, rd, ng, nv); chk("t3_rd00", 32'(rd), 32'h00);

    // T4a: reset before the ACCESS edge drops a pending write
    tick(1);
    txn(0, 1'b1, 8'h3C, 8'hA5, rd, ng, nv);
    tick(2);
    set_fields(0, 1'b1, 8'h3C, 8'h5A);
    @(posedge clk); #1;
    chk("t4a_gnt", 32'(gnt[0]), 32'd1);
    chk("t4a_we_before", 32'(ram_we), 32'd1);
    rst_n = 1'b0; req = '0; #1;
    chk("t4a_we_rst", 32'(ram_we), 32'd0);
    chk("t4a_busy_rst", 32'(busy), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    txn(0, 1'b0, 8'h3C, 8'h00, rd, ng, nv); chk("t4a_no_write", 32'(rd), 32'hA5);

    // T4b: reset while in RESP of a read
    tick(1);
    set_fields(0, 1'b0, 8'h3C, 8'h00);
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    chk("t4b_busy_resp", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    snap = pulse_cnt;
    chk("t4b_rvalid", 32'(rvalid), 32'd0);
    chk("t4b_ram_we", 32'(ram_we), 32'd0);
    chk("t4b_busy", 32'(busy), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    tick(4);
    chk("t4b_no_pulse", 32'(pulse_cnt - snap), 32'd0);
    chk("t4b_busy_after", 32'(busy), 32'd0);

    // T5: lone requester, back-to-back reads
    set_fields(1, 1'b0, 8'h10, 8'h00);
    k = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      chk("t5_busy", 32'(busy), 32'(c % 3 != 0));
      chk("t5_gnt1", 32'(gnt[1]), 32'(c % 3 == 1));
      if (c % 3 == 0) begin
        chk("t5_rvalid1", 32'(rvalid[1]), 32'd1);
        chk("t5_rdata", 32'(rdata), 32'(t5_exp[c/3 - 1]));
      end
      if (gnt[1]) begin
        k++;
        if (k < 3) req_addr[AW +: AW] = 8'(8'h10 + k);
        else req[1] = 1'b0;
      end
    end

    // Seeded random traffic against the shadow model
    ng = $urandom(32'd1234);
    tick(1);
    for (int i = 0; i < 8; i++) txn(i % 2, 1'b1, 8'(8'h20 + i), 8'($urandom), rd, ng, nv);
    for (int i = 0; i < 50; i++) begin
      int p;
      logic we;
      logic [AW-1:0] a;
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 8'(8'h20 + $urandom_range(0, 7));
      txn(p, we, a, 8'($urandom), rd, ng, nv);
      if (!we) chk("rnd_read", 32'(rd), 32'(shadow[a]));
      if ($urandom_range(0, 1) == 1) tick(1);
    end

    chk("onehot_gnt_rvalid", 32'(multi_hot), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
